// File: rtl/joypad_pkg.sv
// Shared constants for the arcade joypad conditioner: button bit positions
// within one player station and a helper for sizing the auto-repeat counter.
// Optional feature macro used by the design: JOYPAD_AUTO_REPEAT_EN.
package joypad_pkg;

  localparam int BTNS_PER_PLAYER = 8;

  localparam int BTN_LFT   = 0;
  localparam int BTN_RGT   = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DN    = 3;
  localparam int BTN_S1    = 4;
  localparam int BTN_S2    = 5;
  localparam int BTN_S3    = 6;
  localparam int BTN_START = 7;

  // Width of a hold counter that must reach both the first-repeat delay and
  // the repeat period.
  function automatic int hold_width(input int delay, input int period);
    return $clog2((delay > period) ? delay : period);
  endfunction

endpackage

// File: rtl/joypad_debounce_bit.sv
// One conditioned button: 2-FF synchroniser of the inverted active-low pin,
// counter debounce, one-cycle press/release pulses and, when
// JOYPAD_AUTO_REPEAT_EN is defined, auto-repeat pulses on btn_press while held.
module joypad_debounce_bit
  import joypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_n,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             repeat_fire;

  // The synchronised level has differed from the accepted level long enough.
  assign accept = (s2 != btn_level) && (cnt == CNT_MAX);

  // Synchroniser, debounce counter, accepted level and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so s2 takes the old s1, giving two real
      // flop stages; blocking here would collapse the synchroniser to one.
      s1 <= ~pad_n;
      s2 <= s1;
      if (s2 == btn_level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt       <= '0;
        btn_level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
      btn_press   <= (accept & s2) | repeat_fire;
      btn_release <= accept & ~s2;
    end
  end

`ifdef JOYPAD_AUTO_REPEAT_EN
  localparam int               HOLD_W      = hold_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HOLD_W-1:0] hold;

  // A release being accepted this cycle suppresses any coincident repeat.
  assign repeat_fire = btn_level && !accept && (hold == HOLD_FIRE);

  // Hold timer: runs while the button is accepted as pressed, reloading after
  // each repeat so later pulses are REPEAT_PERIOD apart.
  always_ff @(posedge clk) begin
    if (rst || !btn_level) begin
      hold <= '0;
    end else if (hold == HOLD_FIRE) begin
      hold <= HOLD_RELOAD;
    end else begin
      hold <= hold + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/joypad_conditioner.sv
// Conditions NUM_PLAYERS x 8 active-low cabinet inputs into debounced
// active-high levels plus press/release pulses, and a registered any_press.
// Optional feature macro: JOYPAD_AUTO_REPEAT_EN (auto-repeat on btn_press).
module joypad_conditioner
  import joypad_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] pad_n,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_level,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_press,
  output logic [NUM_PLAYERS*BTNS_PER_PLAYER-1:0] btn_release,
  output logic                                 any_press
);

  localparam int NUM_BTNS = NUM_PLAYERS * BTNS_PER_PLAYER;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_bit
    joypad_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_bit (
      .clk         (clk),
      .rst         (rst),
      .pad_n       (pad_n[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

  // One-cycle-late summary of any press pulse for wake/attract logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |btn_press;
    end
  end

endmodule

// File: tb/tb_joypad_conditioner.sv
// Directed bench for joypad_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expected pulse events are queued when
// stimulus is applied and matched against every pulse the design emits.
// Repeat checks are included when JOYPAD_AUTO_REPEAT_EN is defined.
module tb_joypad_conditioner;

  localparam int NP = 2;
  localparam int NB = NP * 8;
  localparam int D  = 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_ANY   = 2;

  typedef struct packed {
    int         cyc;
    logic [1:0] kind;
    int         bitn;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] pad_n;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic          any_press;

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];

  joypad_conditioner #(
    .NUM_PLAYERS     (NP),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pad_n       (pad_n),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .any_press   (any_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic expect_ev(input int c, input int k, input int b);
    ev_t e;
    e.cyc  = c;
    e.kind = 2'(k);
    e.bitn = b;
    exp_q.push_back(e);
  endtask

  // Match one observed pulse against the oldest outstanding expectation.
  task automatic observe(input int k, input int b);
    ev_t got;
    ev_t want;
    got.cyc  = cyc;
    got.kind = 2'(k);
    got.bitn = b;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
    end else begin
      want.cyc  = -1;
      want.kind = 2'd3;
      want.bitn = -1;
    end
    tests++;
    assert (got === want)
    else begin
      fails++;
      $error("FAIL event got cyc=%0d kind=%0d bit=%0d expected cyc=%0d kind=%0d bit=%0d",
             got.cyc, got.kind, got.bitn, want.cyc, want.kind, want.bitn);
    end
  endtask

  // Monitor: flags overdue expectations, then matches every emitted pulse.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      tests++;
      fails++;
      $error("FAIL missing_event cyc=%0d kind=%0d bit=%0d not seen by cycle %0d",
             exp_q[0].cyc, exp_q[0].kind, exp_q[0].bitn, cyc);
      void'(exp_q.pop_front());
    end
    for (int b = 0; b < NB; b++) if (btn_press[b] === 1'b1) observe(K_PRESS, b);
    for (int b = 0; b < NB; b++) if (btn_release[b] === 1'b1) observe(K_REL, b);
    if (any_press === 1'b1) observe(K_ANY, 0);
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    pad_n = '1;

    // Reset state.
    wait_to(1);
    check("rst_level",   64'(btn_level),   64'd0);
    check("rst_press",   64'(btn_press),   64'd0);
    check("rst_release", 64'(btn_release), 64'd0);
    check("rst_any",     64'(any_press),   64'd0);
    wait_to(2);
    rst = 1'b0;

    // Basic press on bit 0: sampled at edge 5, accepted at edge 10.
    wait_to(4);
    pad_n[0] = 1'b0;
    expect_ev(10, K_PRESS, 0);
    expect_ev(11, K_ANY, 0);
    wait_to(9);
    check("b0_level_before", 64'(btn_level[0]), 64'd0);
    wait_to(10);
    check("b0_level_accept", 64'(btn_level[0]), 64'd1);
    check("b0_press_accept", 64'(btn_press[0]), 64'd1);
    wait_to(11);
    check("b0_press_oneshot", 64'(btn_press[0]), 64'd0);
    check("b0_any", 64'(any_press), 64'd1);
    wait_to(12);
    pad_n[0] = 1'b1;
    expect_ev(18, K_REL, 0);

    // Three-cycle glitch on bit 1 is rejected.
    wait_to(20);
    pad_n[1] = 1'b0;
    wait_to(23);
    pad_n[1] = 1'b1;
    for (int c = 24; c <= 30; c += 2) begin
      wait_to(c);
      check("glitch_level", 64'(btn_level[1]), 64'd0);
    end

    // Player 2 START: press then release.
    wait_to(32);
    pad_n[15] = 1'b0;
    expect_ev(38, K_PRESS, 15);
    expect_ev(39, K_ANY, 0);
    wait_to(40);
    check("p2start_level", 64'(btn_level[15]), 64'd1);
    pad_n[15] = 1'b1;
    expect_ev(46, K_REL, 15);
    wait_to(46);
    check("p2start_release", 64'(btn_release[15]), 64'd1);
    check("p2start_no_press", 64'(btn_press[15]), 64'd0);
    check("p2start_level_off", 64'(btn_level[15]), 64'd0);

    // Alternating bounce on bit 4, then steady press from cycle 52.
    for (int c = 48; c <= 52; c++) begin
      wait_to(c);
      pad_n[4] = (c % 2 == 1);
    end
    expect_ev(58, K_PRESS, 4);
    expect_ev(59, K_ANY, 0);
    wait_to(57);
    check("bounce_level_before", 64'(btn_level[4]), 64'd0);
    wait_to(58);
    check("bounce_level_accept", 64'(btn_level[4]), 64'd1);
    wait_to(60);
    pad_n[4] = 1'b1;
    expect_ev(66, K_REL, 4);

    // Reset while bit 6 press is mid-count; held pin is re-accepted later.
    wait_to(70);
    pad_n[6] = 1'b0;
    wait_to(74);
    rst = 1'b1;
    wait_to(75);
    check("midrst_level",   64'(btn_level),   64'd0);
    check("midrst_press",   64'(btn_press),   64'd0);
    check("midrst_release", 64'(btn_release), 64'd0);
    check("midrst_any",     64'(any_press),   64'd0);
    rst = 1'b0;
    expect_ev(81, K_PRESS, 6);
    expect_ev(82, K_ANY, 0);
    wait_to(80);
    check("midrst_level_before", 64'(btn_level[6]), 64'd0);
    wait_to(81);
    check("midrst_level_accept", 64'(btn_level[6]), 64'd1);
    wait_to(83);
    pad_n[6] = 1'b1;
    expect_ev(89, K_REL, 6);

    // Two bits changing together resolve independently in the same cycle.
    wait_to(92);
    pad_n[9:8] = 2'b00;
    expect_ev(98, K_PRESS, 8);
    expect_ev(98, K_PRESS, 9);
    expect_ev(99, K_ANY, 0);
    wait_to(98);
    check("pair_level", 64'(btn_level[9:8]), 64'd3);
    wait_to(100);
    pad_n[9:8] = 2'b11;
    expect_ev(106, K_REL, 8);
    expect_ev(106, K_REL, 9);

`ifdef JOYPAD_AUTO_REPEAT_EN
    // Hold bit 2: accepted at 116, repeats at +10, +13, +16, ... until release.
    wait_to(110);
    pad_n[2] = 1'b0;
    expect_ev(116, K_PRESS, 2);
    expect_ev(117, K_ANY, 0);
    for (int r = 0; r < 4; r++) begin
      expect_ev(126 + 3 * r, K_PRESS, 2);
      expect_ev(127 + 3 * r, K_ANY, 0);
    end
    expect_ev(138, K_PRESS, 2);
    expect_ev(139, K_REL, 2);
    expect_ev(139, K_ANY, 0);
    wait_to(133);
    pad_n[2] = 1'b1;
`endif

    wait_to(160);
    check("end_levels", 64'(btn_level), 64'd0);
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
